key_event_fifo: RTL
===================

KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 Parameter DEPTH, 4, number of buffered key events; power of two, 2..16.
REQ-002 Parameter SYNC_STAGES, 2, synchronizer flops on key/valid_key; minimum 2.
REQ-003 Port clk  input  1  system clock (50 MHz), sole clock of the block.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port key  input  4  key code from keypad controller; asynchronous to clk; stable while valid_key high.
REQ-006 Port valid_key  input  1  keypad controller key-held level; asynchronous to clk.
REQ-007 Port ev_ready  input  1  game FSM accepts head event this cycle.
REQ-008 Port ov_clear  input  1  clears overflow and bad_key sticky flags.
REQ-009 Port ev_valid  output  1  FIFO non-empty; head event presented on ev_key.
REQ-010 Port ev_key  output  4  head key code, first-word-fall-through.
REQ-011 Port count  output  5  number of stored events, 0..DEPTH.
REQ-012 Port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 Port bad_key  output  1  sticky: a press with code > 8 was rejected.

Function
REQ-014 key and valid_key SHALL each pass through SYNC_STAGES flops in clk domain with identical depth.
REQ-015 A press event SHALL be a 0->1 transition of synchronized valid_key; holding the key SHALL generate no further events.
REQ-016 Press FSM states: IDLE (released) and HELD; IDLE->HELD on synced valid_key=1 (emits event), HELD->IDLE on synced valid_key=0; no other transitions.
REQ-017 The event key code SHALL be the synchronized key captured in the same cycle as the IDLE->HELD transition.
REQ-018 Codes 0..8 SHALL be pushed; codes 9..15 SHALL not be pushed and SHALL set bad_key.
REQ-019 Latency: valid_key high before clk edge N SHALL give ev_valid=1 after edge N+SYNC_STAGES (empty FIFO, SYNC_STAGES=2 -> 3 edges inclusive).
REQ-020 Pop SHALL occur on a clk edge with ev_valid=1 and ev_ready=1; ev_ready with ev_valid=0 SHALL be ignored.
REQ-021 ev_key SHALL always show the oldest entry; its value when ev_valid=0 is don't-care.
REQ-022 Events SHALL leave in arrival order; pointers wrap modulo DEPTH.
REQ-023 Push while count=DEPTH and no pop: event dropped, FIFO contents unchanged, overflow set.
REQ-024 Push and pop in the same cycle SHALL both take effect at any count, including full (no overflow) and empty is impossible (no pop when empty).
REQ-025 count SHALL equal pushes minus pops, never exceeding DEPTH or going below 0.
REQ-026 ov_clear SHALL clear overflow and bad_key next edge; a simultaneous set event SHALL win (flag stays 1).

Reset
REQ-027 reset SHALL force: ev_valid=0, count=0, overflow=0, bad_key=0, pointers=0, FSM=IDLE, synchronizer flops=0.
REQ-028 reset SHALL take priority over push, pop and ov_clear in the same cycle.
REQ-029 A key held across reset deassertion SHALL produce one event after reset (synchronizer restarts from 0).
REQ-030 Storage array contents need not be reset.

Structure
REQ-031 Key code width (4), valid key count (9) and max valid code (8) SHALL live in the shared WAM definitions include file.
REQ-032 The synchronizer SHALL be a sub-module key_sync (parameterized width and stages), instantiated once for {valid_key, key}.
REQ-033 FIFO storage, pointers, FSM and flags SHALL reside in key_event_fifo itself; no other sub-modules.

Verification
REQ-034 Single press: key=5, valid_key high 10 cycles, ev_ready=0 -> ev_valid=1 after 3 edges, ev_key=5, count=1, exactly one event.
REQ-035 Ordering: presses 1,2,3 (release between), then ev_ready=1 -> ev_key 1,2,3 in successive cycles, count 3->0, ev_valid=0.
REQ-036 Overflow: DEPTH=4, five presses 0..4, ev_ready=0 -> count=4, overflow=1, queue holds 0..3; ov_clear -> overflow=0.
REQ-037 Full push+pop: count=4, press 7 with ev_ready=1 on push cycle -> count stays 4, overflow=0, 7 at tail.
REQ-038 Bad code: press key=12 -> no event, count unchanged, bad_key=1.
REQ-039 Reset mid-hold: key=3 held, reset pulsed 1 cycle while FIFO holds 2 events -> count=0, then one event with ev_key=3.

Source files
------------

// File: rtl/key_event_fifo_pkg.sv
// Shared keypad event definitions: code width, legal code range and press FSM states.
package key_event_fifo_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = 9;
    localparam logic [KEY_W-1:0] MAX_KEY = KEY_W'(NUM_KEYS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } press_state_e;

    function automatic logic key_is_valid(input logic [KEY_W-1:0] k);
        return k <= MAX_KEY;
    endfunction

endpackage

// File: rtl/key_event_fifo_sync.sv
// Multi-flop synchronizer; all bits share the same depth so code and strobe stay aligned.
module key_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_event_fifo.sv
// Keypad press detector feeding a first-word-fall-through event FIFO with
// sticky overflow / illegal-code flags.
module key_event_fifo
    import key_event_fifo_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key,
    input  logic             valid_key,
    input  logic             ev_ready,
    input  logic             ov_clear,
    output logic             ev_valid,
    output logic [KEY_W-1:0] ev_key,
    output logic [4:0]       count,
    output logic             overflow,
    output logic             bad_key
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [KEY_W-1:0] key_s;
    logic             valid_s;

    key_sync #(.WIDTH(KEY_W + 1), .STAGES(SYNC_STAGES)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({valid_key, key}),
        .q     ({valid_s, key_s})
    );

    press_state_e state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             overflow_q, overflow_d, bad_key_q, bad_key_d;
    logic [DEPTH-1:0][KEY_W-1:0] mem_q, mem_d;
    logic             press, code_ok, full, push, pop, ov_set, bad_set;

    always_comb begin
        state_d = state_q;
        press   = 1'b0;
        case (state_q)
            ST_IDLE: if (valid_s) begin
                state_d = ST_HELD;
                press   = 1'b1;
            end
            ST_HELD: if (!valid_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        code_ok = key_is_valid(key_s);
        full    = (count_q == 5'(DEPTH));
        pop     = ev_ready && (count_q != 5'd0);
        // A pop frees the slot in the same edge, so a full FIFO still accepts.
        push    = press && code_ok && (!full || pop);
        ov_set  = press && code_ok && full && !pop;
        bad_set = press && !code_ok;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + 5'(push) - 5'(pop);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = key_s;

        overflow_d = ov_set  | (overflow_q & ~ov_clear);
        bad_key_d  = bad_set | (bad_key_q  & ~ov_clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bad_key_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            bad_key_q  <= bad_key_d;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ev_valid = (count_q != 5'd0);
    assign ev_key   = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign bad_key  = bad_key_q;

endmodule
